// File: rtl/hs65_gs_cell_bank.sv
// rtl/hs65_gs_cell_bank.sv - HS65 GS AND3ABC / AO222 / AOI13 cells with registered copies and toggle counters
module hs65_gs_cell_bank #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    input  logic             and3_a,
    input  logic             and3_b,
    input  logic             and3_c,
    output logic             and3_z,
    output logic             and3_zq,
    output logic [CNT_W-1:0] and3_tog,
    input  logic             ao222_a,
    input  logic             ao222_b,
    input  logic             ao222_c,
    input  logic             ao222_d,
    input  logic             ao222_e,
    input  logic             ao222_f,
    output logic             ao222_z,
    output logic             ao222_zq,
    output logic [CNT_W-1:0] ao222_tog,
    input  logic             aoi13_a,
    input  logic             aoi13_b,
    input  logic             aoi13_c,
    input  logic             aoi13_d,
    output logic             aoi13_z,
    output logic             aoi13_zq,
    output logic [CNT_W-1:0] aoi13_tog
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       z_vec;
    logic [2:0]       zq_vec;
    logic [CNT_W-1:0] tog_q [3];

    assign and3_z  = ~and3_a & ~and3_b & ~and3_c;
    assign ao222_z = (ao222_a & ao222_b) | (ao222_c & ao222_d) | (ao222_e & ao222_f);
    assign aoi13_z = ~((aoi13_a & aoi13_b & aoi13_c) | aoi13_d);

    assign z_vec = {aoi13_z, ao222_z, and3_z};

    always_ff @(posedge clk) begin
        if (rst) begin
            zq_vec <= '0;
        end else begin
            zq_vec <= z_vec;
        end
    end

    // A toggle is counted on the edge where the register is about to change.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || cnt_clr) begin
                tog_q[i] <= '0;
            end else if ((z_vec[i] != zq_vec[i]) && (tog_q[i] != CNT_MAX)) begin
                tog_q[i] <= tog_q[i] + 1'b1;
            end
        end
    end

    assign and3_zq   = zq_vec[0];
    assign ao222_zq  = zq_vec[1];
    assign aoi13_zq  = zq_vec[2];
    assign and3_tog  = tog_q[0];
    assign ao222_tog = tog_q[1];
    assign aoi13_tog = tog_q[2];

endmodule

// File: tb/tb_hs65_gs_cell_bank.sv
// tb/tb_hs65_gs_cell_bank.sv - self-checking bench for hs65_gs_cell_bank
module tb_hs65_gs_cell_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_clr;
    logic [2:0] i3;
    logic [5:0] i6;
    logic [3:0] i4;

    logic       and3_z, and3_zq, ao222_z, ao222_zq, aoi13_z, aoi13_zq;
    logic [7:0] and3_tog, ao222_tog, aoi13_tog;
    logic       and3_z2, and3_zq2, ao222_z2, ao222_zq2, aoi13_z2, aoi13_zq2;
    logic [1:0] and3_tog2, ao222_tog2, aoi13_tog2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] m_zq;
    int         m_t8 [3];
    int         m_t2 [3];

    always #5 clk = ~clk;

    hs65_gs_cell_bank #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr),
        .and3_a(i3[2]), .and3_b(i3[1]), .and3_c(i3[0]),
        .and3_z(and3_z), .and3_zq(and3_zq), .and3_tog(and3_tog),
        .ao222_a(i6[5]), .ao222_b(i6[4]), .ao222_c(i6[3]),
        .ao222_d(i6[2]), .ao222_e(i6[1]), .ao222_f(i6[0]),
        .ao222_z(ao222_z), .ao222_zq(ao222_zq), .ao222_tog(ao222_tog),
        .aoi13_a(i4[3]), .aoi13_b(i4[2]), .aoi13_c(i4[1]), .aoi13_d(i4[0]),
        .aoi13_z(aoi13_z), .aoi13_zq(aoi13_zq), .aoi13_tog(aoi13_tog)
    );

    hs65_gs_cell_bank #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr),
        .and3_a(i3[2]), .and3_b(i3[1]), .and3_c(i3[0]),
        .and3_z(and3_z2), .and3_zq(and3_zq2), .and3_tog(and3_tog2),
        .ao222_a(i6[5]), .ao222_b(i6[4]), .ao222_c(i6[3]),
        .ao222_d(i6[2]), .ao222_e(i6[1]), .ao222_f(i6[0]),
        .ao222_z(ao222_z2), .ao222_zq(ao222_zq2), .ao222_tog(ao222_tog2),
        .aoi13_a(i4[3]), .aoi13_b(i4[2]), .aoi13_c(i4[1]), .aoi13_d(i4[0]),
        .aoi13_z(aoi13_z2), .aoi13_zq(aoi13_zq2), .aoi13_tog(aoi13_tog2)
    );

    typedef struct {
        logic [2:0] a3;
        logic [5:0] a6;
        logic [3:0] a4;
        logic [2:0] exp_z;   // {and3, ao222, aoi13}
    } vec_t;

    vec_t vecs [6];

    // Reference cells written from the truth-table rules, not gate equations.
    function automatic logic [2:0] ref_z(logic [2:0] a3, logic [5:0] a6, logic [3:0] a4);
        logic and3, ao, aoi;
        and3 = ($countones(a3) == 0);
        ao   = (a6[5:4] == 2'b11) || (a6[3:2] == 2'b11) || (a6[1:0] == 2'b11);
        aoi  = !(a4[0] || ($countones(a4[3:1]) == 3));
        return {aoi, ao, and3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge, then compare all registered outputs.
    task automatic tick();
        logic [2:0] z;
        z = ref_z(i3, i6, i4);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_zq[k] = 1'b0;
                m_t8[k] = 0;
                m_t2[k] = 0;
            end else begin
                if (cnt_clr) begin
                    m_t8[k] = 0;
                    m_t2[k] = 0;
                end else if (z[k] != m_zq[k]) begin
                    m_t8[k] = (m_t8[k] + 1 > 255) ? 255 : m_t8[k] + 1;
                    m_t2[k] = (m_t2[k] + 1 > 3) ? 3 : m_t2[k] + 1;
                end
                m_zq[k] = z[k];
            end
        end
        @(posedge clk);
        #1;
        check("zq", {29'd0, aoi13_zq, ao222_zq, and3_zq}, {29'd0, m_zq});
        check("zq_w2", {29'd0, aoi13_zq2, ao222_zq2, and3_zq2}, {29'd0, m_zq});
        check("and3_tog", {24'd0, and3_tog}, m_t8[0]);
        check("ao222_tog", {24'd0, ao222_tog}, m_t8[1]);
        check("aoi13_tog", {24'd0, aoi13_tog}, m_t8[2]);
        check("and3_tog_w2", {30'd0, and3_tog2}, m_t2[0]);
        check("ao222_tog_w2", {30'd0, ao222_tog2}, m_t2[1]);
        check("aoi13_tog_w2", {30'd0, aoi13_tog2}, m_t2[2]);
    endtask

    task automatic check_comb(input string name);
        #1;
        check(name, {29'd0, aoi13_z, ao222_z, and3_z}, {29'd0, ref_z(i3, i6, i4)});
    endtask

    initial begin
        vecs[0] = '{3'b000, 6'b110000, 4'b0000, 3'b111};
        vecs[1] = '{3'b001, 6'b101010, 4'b1110, 3'b000};
        vecs[2] = '{3'b100, 6'b000011, 4'b0001, 3'b010};
        vecs[3] = '{3'b111, 6'b001100, 4'b1100, 3'b011};
        vecs[4] = '{3'b010, 6'b010101, 4'b1011, 3'b000};
        vecs[5] = '{3'b000, 6'b111111, 4'b0111, 3'b110};

        rst = 1'b1; cnt_clr = 1'b0; i3 = '0; i6 = '0; i4 = '0;
        m_zq = '0;
        for (int k = 0; k < 3; k++) begin m_t8[k] = 0; m_t2[k] = 0; end
        tick();
        tick();
        check("reset_zq", {29'd0, aoi13_zq, ao222_zq, and3_zq}, 32'd0);
        check("reset_tog", {8'd0, aoi13_tog, ao222_tog, and3_tog}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            i3 = vecs[v].a3; i6 = vecs[v].a6; i4 = vecs[v].a4;
            #1;
            check("table_z", {29'd0, and3_z, ao222_z, aoi13_z}, {29'd0, vecs[v].exp_z});
            tick();
        end

        for (int c = 0; c < 8; c++) begin
            i3 = c[2:0];
            check_comb("and3_exh");
            tick();
        end
        for (int c = 0; c < 64; c++) begin
            i6 = c[5:0];
            check_comb("ao222_exh");
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            i4 = c[3:0];
            check_comb("aoi13_exh");
            tick();
        end

        // Reset held with an active AO222 pair, then released.
        i3 = 3'b111; i6 = 6'b110000; i4 = 4'b0001; rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_hold_zq", {31'd0, ao222_zq}, 32'd0);
            check("rst_hold_tog", {24'd0, ao222_tog}, 32'd0);
        end
        rst = 1'b0;
        tick();
        check("rst_rel_zq", {31'd0, ao222_zq}, 32'd1);
        check("rst_rel_tog", {24'd0, ao222_tog}, 32'd1);

        // Saturation on the 2-bit instance.
        i4 = 4'b0000; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i4[0] = ~i4[0];
            tick();
            check("sat_tog", {30'd0, aoi13_tog2}, (c + 1 > 3) ? 3 : c + 1);
        end
        cnt_clr = 1'b1;
        tick();
        check("clr_tog", {30'd0, aoi13_tog2}, 32'd0);
        check("clr_zq", {31'd0, aoi13_zq2}, 32'd1);
        cnt_clr = 1'b0;

        // rst and cnt_clr together with nonzero counts.
        i4[0] = 1'b1; tick();
        i4[0] = 1'b0; tick();
        rst = 1'b1; cnt_clr = 1'b1;
        tick();
        check("both_zq", {29'd0, aoi13_zq, ao222_zq, and3_zq}, 32'd0);
        check("both_tog", {8'd0, aoi13_tog, ao222_tog, and3_tog}, 32'd0);
        rst = 1'b0; cnt_clr = 1'b0;

        for (int c = 0; c < 400; c++) begin
            i3 = 3'($urandom_range(0, 7));
            i6 = 6'($urandom_range(0, 63));
            i4 = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 39) == 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            check_comb("rand_z");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
